// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM encoding and timing defaults for the peripheral bus read sequencer
package bus_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_ACK} state_e;
  localparam int DEF_SETUP = 1;
  localparam int DEF_STROBE = 2;
  localparam int DEF_HOLD = 1;
  localparam int CNT_W = 4;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter with a registered last-grant pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       gnt_id
);
  logic last_q;
  assign gnt_id = &req ? ~last_q : req[1];
  // pointer starts as "1 granted last" so requester 0 wins the first tie
  always_ff @(posedge clk or posedge reset)
    if (reset) last_q <= 1'b1;
    else if (grant_en) last_q <= gnt_id;
endmodule

// File: rtl/bus_read_sched.sv
// bus_read_sched: arbitrated read-cycle sequencer for the shared 8-bit peripheral bus
module bus_read_sched
  import bus_pkg::*;
#(
  parameter int AW = 2,
  parameter int SETUP = DEF_SETUP,
  parameter int STROBE = DEF_STROBE,
  parameter int HOLD = DEF_HOLD,
  localparam int N_DEV = 2 ** AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [AW-1:0]    addr0,
  output logic             ack0,
  input  logic             req1,
  input  logic [AW-1:0]    addr1,
  output logic             ack1,
  output logic [7:0]       rdata,
  output logic [N_DEV-1:0] ce_n,
  output logic             read_n,
  input  logic [7:0]       bus_data,
  output logic             busy
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic id_q, gnt_id, grant_en;
  logic [AW-1:0] addr_q;
  logic [N_DEV-1:0] ce_n_q;
  logic read_n_q, ack0_q, ack1_q;
  logic [7:0] rdata_q;
  assign grant_en = state_q == S_IDLE && (req0 || req1);
  assign busy = state_q != S_IDLE;
  assign ce_n = ce_n_q;
  assign read_n = read_n_q;
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign rdata = rdata_q;
  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1, req0}),
    .grant_en(grant_en),
    .gnt_id  (gnt_id)
  );
  // next state: each wait phase reloads the counter on entry and leaves when it reaches zero
  always_comb begin
    state_d = state_q;
    cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    case (state_q)
      S_IDLE: if (grant_en) begin state_d = S_SETUP; cnt_d = CNT_W'(SETUP - 1); end
      S_SETUP: if (cnt_q == '0) begin state_d = S_STROBE; cnt_d = CNT_W'(STROBE - 1); end
      S_STROBE: if (cnt_q == '0) begin state_d = S_HOLD; cnt_d = CNT_W'(HOLD - 1); end
      S_HOLD: if (cnt_q == '0) state_d = S_ACK;
      default: state_d = S_IDLE;
    endcase
  end
  // state, counter and the grant latched at the IDLE exit
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      id_q <= 1'b0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (grant_en) begin
        id_q <= gnt_id;
        addr_q <= gnt_id ? addr1 : addr0;
      end
    end
  // bus pins are registered from the current state so they change cleanly one cycle behind it;
  // data is captured on the edge that closes the last visible strobe cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ce_n_q <= '1;
      read_n_q <= 1'b1;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      ce_n_q <= (state_q inside {S_SETUP, S_STROBE, S_HOLD}) ? ~(N_DEV'(1) << addr_q) : '1;
      read_n_q <= state_q != S_STROBE;
      ack0_q <= state_q == S_ACK && !id_q;
      ack1_q <= state_q == S_ACK && id_q;
      if (state_q == S_HOLD && !read_n_q) rdata_q <= bus_data;
    end
endmodule

// File: tb/tb_bus_read_sched.sv
// tb_bus_read_sched: directed checks of the default and a stretched-timing read sequencer
module tb_bus_read_sched;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic req0 = 0, req1 = 0, ack0, ack1, read_n, busy;
  logic [1:0] addr0 = 0, addr1 = 0;
  logic [7:0] rdata, bus_data;
  logic [3:0] ce_n;
  logic b_req0 = 0, b_req1 = 0, b_ack0, b_ack1, b_read_n, b_busy;
  logic [1:0] b_addr0 = 0, b_addr1 = 0;
  logic [7:0] b_rdata, b_bus = 8'h00;
  logic [3:0] b_ce_n;
  logic [7:0] dev [4] = '{8'h11, 8'h5C, 8'hA5, 8'h33};
  int n_chk = 0, n_err = 0;

  bus_read_sched u0 (
    .clk(clk), .reset(reset), .req0(req0), .addr0(addr0), .ack0(ack0), .req1(req1), .addr1(addr1),
    .ack1(ack1), .rdata(rdata), .ce_n(ce_n), .read_n(read_n), .bus_data(bus_data), .busy(busy));
  bus_read_sched #(.SETUP(3), .STROBE(1), .HOLD(2)) u1 (
    .clk(clk), .reset(reset), .req0(b_req0), .addr0(b_addr0), .ack0(b_ack0), .req1(b_req1),
    .addr1(b_addr1), .ack1(b_ack1), .rdata(b_rdata), .ce_n(b_ce_n), .read_n(b_read_n),
    .bus_data(b_bus), .busy(b_busy));

  // the selected device drives its value; an undriven bus reads as FF
  always_comb begin
    bus_data = 8'hFF;
    for (int i = 0; i < 4; i++) if (ce_n == ~(4'b0001 << i)) bus_data = dev[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ce_onehot0", $countones(~ce_n) <= 1, 1);
    chk("rd_excl", read_n || $countones(~ce_n) == 1, 1);
    chk("b_ce_onehot0", $countones(~b_ce_n) <= 1, 1);
    chk("b_rd_excl", b_read_n || $countones(~b_ce_n) == 1, 1);
  end

  typedef struct {
    bit d; bit id; logic [1:0] addr; logic [7:0] bus; logic [7:0] exp_rd; logic [3:0] exp_ce;
    int rd_first; int rd_last; int ack_k;
  } vec_t;
  vec_t v[5];

  task automatic run_vec(input vec_t t);
    logic [3:0] c;
    logic r, am, ao;
    logic [7:0] rd;
    @(negedge clk);
    if (t.d) begin
      b_bus = t.bus;
      if (t.id) begin b_req1 = 1; b_addr1 = t.addr; end else begin b_req0 = 1; b_addr0 = t.addr; end
    end else if (t.id) begin req1 = 1; addr1 = t.addr; end
    else begin req0 = 1; addr0 = t.addr; end
    for (int k = 0; k <= t.ack_k + 1; k++) begin
      @(posedge clk); #1;
      c = t.d ? b_ce_n : ce_n;
      r = t.d ? b_read_n : read_n;
      am = t.id ? (t.d ? b_ack1 : ack1) : (t.d ? b_ack0 : ack0);
      ao = t.id ? (t.d ? b_ack0 : ack0) : (t.d ? b_ack1 : ack1);
      rd = t.d ? b_rdata : rdata;
      chk("vec_ce_n", c, (k >= 1 && k < t.ack_k) ? t.exp_ce : 4'hF);
      chk("vec_read_n", r, (k >= t.rd_first && k <= t.rd_last) ? 0 : 1);
      chk("vec_ack", am, k == t.ack_k);
      chk("vec_ack_other", ao, 0);
      if (k == t.ack_k) begin
        chk("vec_rdata", rd, t.exp_rd);
        req0 = 0; req1 = 0; b_req0 = 0; b_req1 = 0;
      end
      if (t.d && k == t.rd_last + 1) b_bus = ~t.bus;
    end
  endtask

  initial begin
    int e, nack, last;
    v[0] = '{0, 0, 2'd2, 8'h00, 8'hA5, 4'b1011, 2, 3, 5};
    v[1] = '{0, 1, 2'd3, 8'h00, 8'h33, 4'b0111, 2, 3, 5};
    v[2] = '{0, 0, 2'd0, 8'h00, 8'h11, 4'b1110, 2, 3, 5};
    v[3] = '{1, 0, 2'd1, 8'h5A, 8'h5A, 4'b1101, 4, 4, 7};
    v[4] = '{1, 1, 2'd3, 8'h9E, 8'h9E, 4'b0111, 4, 4, 7};
    req0 = 1; req1 = 1; addr0 = 0; addr1 = 3;
    #22;
    chk("rst_ce_n", ce_n, 4'hF);
    chk("rst_read_n", read_n, 1);
    chk("rst_acks", {ack0, ack1}, 0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_busy", busy, 0);
    @(negedge clk) reset = 0;
    e = 0; nack = 0; last = 0;
    while (nack < 4 && e < 40) begin
      @(posedge clk); #1;
      e++;
      if (ack0 || ack1) begin
        chk("rr_ack_id", {ack1, ack0}, (nack % 2) ? 2'b10 : 2'b01);
        chk("rr_rdata", rdata, (nack % 2) ? 8'h33 : 8'h11);
        chk("rr_spacing", e - last, 6);
        last = e;
        nack++;
      end
    end
    chk("rr_ack_count", nack, 4);
    req0 = 0; req1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) begin req0 = 1; addr0 = 2; end
    repeat (3) @(posedge clk);
    #1 chk("mid_read_n_low", read_n, 0);
    #2 reset = 1;
    #1;
    chk("mid_rst_ce_n", ce_n, 4'hF);
    chk("mid_rst_read_n", read_n, 1);
    chk("mid_rst_rdata", rdata, 8'h00);
    chk("mid_rst_busy", busy, 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_ack", {ack0, ack1}, 0);
    end
    @(negedge clk) reset = 0;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      chk("restart_ce_n", ce_n, (k >= 1 && k <= 4) ? 4'b1011 : 4'hF);
      chk("restart_ack0", ack0, k == 5);
      if (k == 5) begin chk("restart_rdata", rdata, 8'hA5); req0 = 0; end
    end
    for (int i = 0; i < 5; i++) run_vec(v[i]);
    @(negedge clk) begin req1 = 1; addr1 = 1; end
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin req1 = 0; addr1 = 2; end
      chk("addr_hold_ce_n", ce_n, (k >= 1 && k <= 4) ? 4'b1101 : 4'hF);
      chk("addr_hold_ack1", ack1, k == 5);
      if (k == 5) chk("addr_hold_rdata", rdata, 8'h5C);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bus_read_sched.md
Name: bus_read_sched

Overview:
Sequences read cycles on the shared 8-bit peripheral bus and shares the bus between two requesters. Each requester is either the host-interface port or the display-refresh port. Each transaction is one read of one device: switch input, status, and so on. The block drives a one-hot-low chip enable and read_n with programmable setup, strobe and hold wait states. It captures the tri-stated bus data and returns it to the winning requester with a one-cycle ack. Arbitration is round-robin.

Parameters:
AW, 2, device address width; N_DEV = 2**AW chip enables.
SETUP, 1, cycles ce_n is low before read_n falls (range 1..15).
STROBE, 2, cycles read_n is low (range 1..15).
HOLD, 1, cycles ce_n stays low after read_n rises (range 1..15).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req0  in  1  requester 0 read request, level
addr0  in  AW  requester 0 device select
ack0  out  1  one-cycle pulse: rdata valid for requester 0
req1  in  1  requester 1 read request, level
addr1  in  AW  requester 1 device select
ack1  out  1  one-cycle pulse: rdata valid for requester 1
rdata  out  8  captured read data, held until next capture
ce_n  out  N_DEV  active-low chip enables, at most one low
read_n  out  1  active-low read strobe
bus_data  in  8  shared bus data (driven by selected device)
busy  out  1  high in any non-IDLE state

Behaviour:
- Reset (asynchronous, immediate):
  - ce_n all 1, read_n 1, ack0/ack1 0, rdata 8'h00, busy 0.
  - State IDLE; round-robin pointer favours req0.
- FSM states:
  - IDLE: samples req0/req1. If any is high, latch the winner id and its addr, then go to SETUP.
  - SETUP: ce_n[addr] low, read_n high, for SETUP cycles. Then go to STROBE.
  - STROBE: ce_n[addr] low, read_n low, for STROBE cycles. On the last STROBE cycle's closing edge, capture bus_data into rdata. Then go to HOLD.
  - HOLD: ce_n[addr] low, read_n high, for HOLD cycles. Then go to ACK.
  - ACK: all ce_n high, read_n high, ack of the granted requester = 1. Next state IDLE.
- ACK is also the mandatory one-cycle bus turnaround; IDLE never grants in the same cycle as ACK.
- All outputs are registered; no combinational path from req/addr to ce_n/read_n/ack.
- Latency: a request sampled high at edge E produces ack high at edge E+SETUP+STROBE+HOLD+1, i.e. E+5 with defaults. A back-to-back grant occurs at the earliest 2 edges after ACK is entered.
- Wait-state counter: 4 bits, loaded with (param-1) on state entry, decrements to 0, then transition.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the requester not granted last wins.
  - The pointer updates only on grant.
- Requests are level: a requester must drop req in the cycle it sees ack, or it is serviced again. A req held continuously alternates fairly with the other requester.
- addr is latched at grant; changes to addrX during a transaction are ignored.
- A req dropped mid-transaction does not abort it; the cycle completes and ack still pulses.
- ce_n/read_n never glitch: read_n is low only while exactly one ce_n is low. ce_n changes only on transitions out of IDLE and into ACK.
- Reset asserted mid-transaction: outputs return to reset values immediately and no ack is issued.

Decomposition:
- Shared package bus_pkg:
  - FSM state encoding (IDLE, SETUP, STROBE, HOLD, ACK).
  - Default timing constants (SETUP=1, STROBE=2, HOLD=1).
  - Wait-counter width (4).
- One sub-module: rr_arb2 (two-input round-robin arbiter).
  - Ports: req[1:0], grant_en, gnt_id.
  - Registered last-grant pointer, with the same clk/reset.

Test Plan:
- Reset mid-STROBE (assert at cycle 3) -> ce_n=4'b1111 and read_n=1 in the same cycle; no ack; after release, req0 restarts a full 5-edge cycle.
- req0=1, addr0=2, bus_data=8'hA5, defaults -> ce_n=4'b1011 for 4 cycles, read_n low for exactly 2 of them, ack0 pulse at E+5, rdata=8'hA5, ack1 never high.
- req0 and req1 both high from reset, held, addr0=0 (8'h11), addr1=3 (8'h33) -> grants alternate 0,1,0,1; ack sequence ack0,ack1,ack0,ack1 with rdata 11,33,11,33; each ack 6 edges apart.
- req1 single pulse, with addr1 changed from 1 to 2 during SETUP -> ce_n[1] stays the only low enable throughout; ack1 still pulses; rdata = device-1 value.
- Parameters SETUP=3, STROBE=1, HOLD=2 -> read_n low exactly 1 cycle after 3 setup cycles; ack at E+7; bus_data changing after capture edge does not alter rdata.
- Continuous check across all runs: read_n==0 implies exactly one ce_n bit low; the $countones of ~ce_n never exceeds 1.
